// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding
// and default sizing of the requester/data/burst dimensions.
package fifo_arb_pkg;

    localparam int unsigned N_REQ_DEF     = 4;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 4;

    // Width of the externally visible owner index.
    localparam int unsigned OWNER_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage : fifo_arb_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans upward from last+1 with wrap-around
// and returns a one-hot winner plus a flag saying any request was present.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]   req_i,
    input  logic [OWNER_W-1:0] last_i,
    output logic [N_REQ-1:0]   win_o,
    output logic               valid_o
);

    logic [31:0] idx;

    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        // First hit at offset 1..N_REQ from last; offset N_REQ is last itself.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_i) + k) % N_REQ;
            if (!valid_o && req_i[idx]) begin
                win_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule : rr_picker

// File: rtl/fifo_wr_arbiter.sv
// Grants the shared FIFO write port to one requester at a time for bursts of
// up to MAX_BURST beats, with round-robin fairness and a gap cycle per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [OWNER_W-1:0]      owner,
    output logic                    busy,
    input  logic                    fifo_full,
    output logic                    fifo_wr,
    output logic [DATA_W-1:0]       fifo_data
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q,   gnt_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] last_q,  last_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [N_REQ-1:0]   pick_win;
    logic               pick_valid;
    logic [OWNER_W-1:0] pick_idx;
    logic               owner_req;
    logic               final_beat;

    rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (pick_win),
        .valid_o(pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_win[i]) pick_idx = OWNER_W'(i);
        end
    end

    assign busy       = (state_q == BURST);
    assign owner_req  = req[owner_q];
    assign fifo_wr    = busy && owner_req && !fifo_full;
    assign fifo_data  = busy ? req_data[int'(owner_q)*DATA_W +: DATA_W] : '0;
    assign final_beat = fifo_wr && (cnt_q == CNT_W'(MAX_BURST - 1));
    assign gnt        = gnt_q;
    assign owner      = owner_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BURST;
                    gnt_d   = pick_win;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                // A stalled beat (fifo_full) holds everything, including the grant.
                if (final_beat || !owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (fifo_wr) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= OWNER_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : fifo_wr_arbiter
